erx_deser: RTL and testbench

//  Receive-side deserializer for the eLink. Sits after the input DDR capture

---
 rtl/erx_deser.sv | 138 +++++++++++++
 tb/tb_erx_deser.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/erx_deser.sv
// eLink receive deserializer: packs 16-bit link beats into 64-bit words,
// repairs a one-byte frame skew and stretches wr/rd wait pushback.
module erx_deser #(
  parameter bit INVERT    = 1'b0,
  parameter int WAIT_HOLD = 4
) (
  input  logic        rx_lclk,
  input  logic        reset,
  input  logic [15:0] rx_data16,
  input  logic [1:0]  rx_frame2,
  output logic [63:0] rx_data_wide,
  output logic [3:0]  rx_frame_wide,
  output logic        rx_valid,
  output logic        rx_align_err,
  input  logic        wr_wait_req,
  input  logic        rd_wait_req,
  output logic        rx_wr_wait,
  output logic        rx_rd_wait
);

  typedef enum logic {IDLE, BURST} state_t;

  localparam logic [3:0] HOLD = 4'(WAIT_HOLD);

  state_t      state;
  logic        offset;
  logic [1:0]  slot;
  logic [15:0] data_q;
  logic [1:0]  frame_q;
  logic [63:0] pack_data;
  logic [3:0]  pack_frame;

  logic [15:0] din;
  logic [1:0]  fin;
  logic        start;
  logic        sel_off;
  logic [15:0] word;
  logic        fbit;
  logic        take;

  assign din = rx_data16 ^ {16{INVERT}};
  assign fin = rx_frame2 ^ {2{INVERT}};

  // The first beat of a burst is packed in the same cycle IDLE sees it.
  always_comb begin
    start   = (state == IDLE) &&
              (frame_q == 2'b11 || frame_q == 2'b01);
    sel_off = (state == IDLE) ? (frame_q == 2'b01) : offset;
    word    = sel_off ? {data_q[7:0], din[15:8]} : data_q;
    fbit    = sel_off ? frame_q[0] : frame_q[1];
    take    = start || (state == BURST && fbit);
  end

  always_ff @(posedge rx_lclk) begin
    if (reset) begin
      state         <= IDLE;
      offset        <= 1'b0;
      slot          <= 2'd0;
      data_q        <= '0;
      frame_q       <= '0;
      pack_data     <= '0;
      pack_frame    <= '0;
      rx_data_wide  <= '0;
      rx_frame_wide <= '0;
      rx_valid      <= 1'b0;
      rx_align_err  <= 1'b0;
    end else begin
      data_q       <= din;
      frame_q      <= fin;
      rx_valid     <= 1'b0;
      rx_align_err <= 1'b0;
      if (take) begin
        if (slot == 2'd3) begin
          rx_data_wide  <= {word, pack_data[47:0]};
          rx_frame_wide <= {pack_frame[3:1], 1'b1};
          rx_valid      <= 1'b1;
          pack_data     <= '0;
          pack_frame    <= '0;
          slot          <= 2'd0;
        end else begin
          pack_data[{slot, 4'b0000} +: 16] <= word;
          pack_frame[2'd3 - slot]          <= 1'b1;
          slot                             <= slot + 2'd1;
        end
      end
      unique case (state)
        IDLE: begin
          if (start) begin
            state  <= BURST;
            offset <= (frame_q == 2'b01);
          end else if (frame_q == 2'b10) begin
            rx_align_err <= 1'b1;
          end
        end
        BURST: begin
          if (!fbit) begin
            state <= IDLE;
            if (slot != 2'd0) begin
              rx_data_wide  <= pack_data;
              rx_frame_wide <= pack_frame;
              rx_valid      <= 1'b1;
            end
            pack_data  <= '0;
            pack_frame <= '0;
            slot       <= 2'd0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic [1:0] req;
  logic [3:0] cnt [2];
  logic [1:0] wait_q;

  assign req        = {rd_wait_req, wr_wait_req};
  assign rx_wr_wait = wait_q[0];
  assign rx_rd_wait = wait_q[1];

  // Wait stays up while the request is high and HOLD cycles after it drops.
  always_ff @(posedge rx_lclk) begin
    if (reset) begin
      wait_q <= '0;
      cnt[0] <= '0;
      cnt[1] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        wait_q[i] <= (req[i] || cnt[i] != 4'd0) ^ INVERT;
        if (req[i])
          cnt[i] <= HOLD;
        else if (cnt[i] != 4'd0)
          cnt[i] <= cnt[i] - 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_erx_deser.sv
// Bench for erx_deser: randomized bursts checked against a word-level
// packing model, plus glitch, reset and wait-stretch scenarios.
module tb_erx_deser;

  localparam int HOLD = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] rx_data16;
  logic [1:0]  rx_frame2;
  logic [63:0] rx_data_wide;
  logic [3:0]  rx_frame_wide;
  logic        rx_valid;
  logic        rx_align_err;
  logic        wr_wait_req;
  logic        rd_wait_req;
  logic        rx_wr_wait;
  logic        rx_rd_wait;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int t_last;
  int n_err;

  logic [15:0] words [$];
  logic [63:0] exp_d [$];
  logic [3:0]  exp_f [$];
  logic [63:0] got_d [$];
  logic [3:0]  got_f [$];
  int          got_c [$];

  erx_deser #(.INVERT(1'b0), .WAIT_HOLD(HOLD)) dut (
    .rx_lclk      (clk),
    .reset        (reset),
    .rx_data16    (rx_data16),
    .rx_frame2    (rx_frame2),
    .rx_data_wide (rx_data_wide),
    .rx_frame_wide(rx_frame_wide),
    .rx_valid     (rx_valid),
    .rx_align_err (rx_align_err),
    .wr_wait_req  (wr_wait_req),
    .rd_wait_req  (rd_wait_req),
    .rx_wr_wait   (rx_wr_wait),
    .rx_rd_wait   (rx_rd_wait)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rx_valid) begin
      got_d.push_back(rx_data_wide);
      got_f.push_back(rx_frame_wide);
      got_c.push_back(cyc);
    end
    if (rx_align_err) n_err++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      rx_frame2 = 2'b00;
      rx_data16 = 16'($urandom);
      step();
    end
  endtask

  task automatic clear_all();
    words.delete();
    exp_d.delete();
    exp_f.delete();
    got_d.delete();
    got_f.delete();
    got_c.delete();
    n_err = 0;
  endtask

  task automatic rand_words(input int n);
    words.delete();
    for (int i = 0; i < n; i++) words.push_back(16'($urandom));
  endtask

  // Reference: link words group in fours, first word lowest; a short
  // tail is padded with zero data and zero frame bits.
  task automatic model_pack();
    logic [63:0] d;
    logic [3:0]  f;
    for (int i = 0; i < words.size(); i += 4) begin
      d = '0;
      f = '0;
      for (int j = 0; j < 4; j++) begin
        if (i + j < words.size()) begin
          d[16*j +: 16] = words[i + j];
          f[3 - j] = 1'b1;
        end
      end
      exp_d.push_back(d);
      exp_f.push_back(f);
    end
  endtask

  // Serialize words onto the link, optionally skewed by one byte.
  task automatic drive(input bit off);
    int n;
    logic [15:0] w;
    logic [7:0] hi;
    logic [7:0] lo;
    n = words.size();
    if (!off) begin
      for (int i = 0; i < n; i++) begin
        rx_data16 = words[i];
        rx_frame2 = 2'b11;
        t_last = cyc;
        step();
      end
    end else begin
      for (int c = 0; c <= n; c++) begin
        hi = 8'($urandom);
        lo = 8'($urandom);
        if (c > 0) begin
          w = words[c - 1];
          hi = w[7:0];
        end
        if (c < n) begin
          w = words[c];
          lo = w[15:8];
        end
        rx_data16 = {hi, lo};
        rx_frame2 = {c > 0, c < n};
        t_last = cyc;
        step();
      end
    end
    idle(6);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    rx_data16 = '0;
    rx_frame2 = '0;
    wr_wait_req = 1'b0;
    rd_wait_req = 1'b0;
    n_err = 0;
    step();
    step();
    step();
    checks += 6;
    if (rx_valid !== 1'b0) begin
      failures++; $display("FAIL reset_valid got=%b exp=0", rx_valid);
    end
    if (rx_data_wide !== 64'd0) begin
      failures++; $display("FAIL reset_data got=%h exp=0", rx_data_wide);
    end
    if (rx_frame_wide !== 4'd0) begin
      failures++; $display("FAIL reset_frame got=%b exp=0", rx_frame_wide);
    end
    if (rx_align_err !== 1'b0) begin
      failures++; $display("FAIL reset_align got=%b exp=0", rx_align_err);
    end
    if (rx_wr_wait !== 1'b0) begin
      failures++; $display("FAIL reset_wrwait got=%b exp=0", rx_wr_wait);
    end
    if (rx_rd_wait !== 1'b0) begin
      failures++; $display("FAIL reset_rdwait got=%b exp=0", rx_rd_wait);
    end
    reset = 1'b0;
    idle(3);
  endtask

  task automatic test_aligned();
    clear_all();
    words = '{16'h0100, 16'h0302, 16'h0504, 16'h0706};
    drive(1'b0);
    checks += 4;
    if (got_d.size() !== 1) begin
      failures++; $display("FAIL aligned_count got=%0d exp=1", got_d.size());
    end else begin
      if (got_d[0] !== 64'h0706050403020100) begin
        failures++; $display("FAIL aligned_data got=%h exp=0706050403020100", got_d[0]);
      end
      if (got_f[0] !== 4'b1111) begin
        failures++; $display("FAIL aligned_frame got=%b exp=1111", got_f[0]);
      end
      if (got_c[0] !== t_last + 2) begin
        failures++; $display("FAIL aligned_latency got=%0d exp=%0d", got_c[0], t_last + 2);
      end
    end
    for (int k = 0; k < 3; k++) begin
      clear_all();
      rand_words(4);
      model_pack();
      drive(1'b0);
      checks += 3;
      if (got_d.size() !== 1) begin
        failures++; $display("FAIL aligned_rand_count got=%0d exp=1", got_d.size());
      end else begin
        if (got_d[0] !== exp_d[0]) begin
          failures++; $display("FAIL aligned_rand_data got=%h exp=%h", got_d[0], exp_d[0]);
        end
        if (got_c[0] !== t_last + 2) begin
          failures++; $display("FAIL aligned_rand_lat got=%0d exp=%0d", got_c[0], t_last + 2);
        end
      end
    end
  endtask

  task automatic test_offset();
    for (int k = 0; k < 3; k++) begin
      clear_all();
      if (k == 0) words = '{16'h0100, 16'h0302, 16'h0504, 16'h0706};
      else rand_words(4);
      model_pack();
      drive(1'b1);
      checks += 4;
      if (got_d.size() !== 1) begin
        failures++; $display("FAIL offset_count got=%0d exp=1", got_d.size());
      end else begin
        if (got_d[0] !== exp_d[0]) begin
          failures++; $display("FAIL offset_data got=%h exp=%h", got_d[0], exp_d[0]);
        end
        if (got_f[0] !== 4'b1111) begin
          failures++; $display("FAIL offset_frame got=%b exp=1111", got_f[0]);
        end
      end
      if (n_err !== 0) begin
        failures++; $display("FAIL offset_align_err got=%0d exp=0", n_err);
      end
    end
  endtask

  task automatic test_partial();
    clear_all();
    words = '{16'hAAAA, 16'hBBBB};
    drive(1'b0);
    checks += 3;
    if (got_d.size() !== 1) begin
      failures++; $display("FAIL partial_count got=%0d exp=1", got_d.size());
    end else begin
      if (got_d[0] !== 64'h00000000BBBBAAAA) begin
        failures++; $display("FAIL partial_data got=%h exp=00000000BBBBAAAA", got_d[0]);
      end
      if (got_f[0] !== 4'b1100) begin
        failures++; $display("FAIL partial_frame got=%b exp=1100", got_f[0]);
      end
    end
  endtask

  task automatic test_back_to_back();
    clear_all();
    rand_words(12);
    model_pack();
    drive(1'b0);
    checks++;
    if (got_d.size() !== 3) begin
      failures++; $display("FAIL b2b_count got=%0d exp=3", got_d.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks += 2;
        if (got_d[i] !== exp_d[i]) begin
          failures++; $display("FAIL b2b_data[%0d] got=%h exp=%h", i, got_d[i], exp_d[i]);
        end
        if (i > 0 && got_c[i] - got_c[i-1] !== 4) begin
          failures++; $display("FAIL b2b_gap[%0d] got=%0d exp=4", i, got_c[i] - got_c[i-1]);
        end
      end
    end
  endtask

  task automatic test_random_bursts();
    bit off;
    for (int k = 0; k < 20; k++) begin
      clear_all();
      off = 1'($urandom);
      rand_words($urandom_range(1, 10));
      model_pack();
      drive(off);
      checks += 2;
      if (got_d.size() !== exp_d.size()) begin
        failures++; $display("FAIL rand_count off=%0d got=%0d exp=%0d", off, got_d.size(), exp_d.size());
      end else begin
        for (int i = 0; i < exp_d.size(); i++) begin
          checks += 2;
          if (got_d[i] !== exp_d[i]) begin
            failures++; $display("FAIL rand_data off=%0d got=%h exp=%h", off, got_d[i], exp_d[i]);
          end
          if (got_f[i] !== exp_f[i]) begin
            failures++; $display("FAIL rand_frame off=%0d got=%b exp=%b", off, got_f[i], exp_f[i]);
          end
        end
      end
      if (n_err !== 0) begin
        failures++; $display("FAIL rand_align_err got=%0d exp=0", n_err);
      end
    end
  endtask

  task automatic test_glitch_reset();
    clear_all();
    rx_frame2 = 2'b10;
    rx_data16 = 16'($urandom);
    step();
    idle(5);
    checks += 2;
    if (n_err !== 1) begin
      failures++; $display("FAIL glitch_pulses got=%0d exp=1", n_err);
    end
    if (got_d.size() !== 0) begin
      failures++; $display("FAIL glitch_valid got=%0d exp=0", got_d.size());
    end
    clear_all();
    for (int i = 0; i < 3; i++) begin
      rx_data16 = 16'($urandom);
      rx_frame2 = 2'b11;
      step();
    end
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    idle(4);
    checks++;
    if (got_d.size() !== 0) begin
      failures++; $display("FAIL reset_burst_valid got=%0d exp=0", got_d.size());
    end
    clear_all();
    rand_words(4);
    model_pack();
    drive(1'b0);
    checks++;
    if (got_d.size() !== 1 || got_d[0] !== exp_d[0]) begin
      failures++; $display("FAIL post_reset_word got_n=%0d exp=%h", got_d.size(), exp_d[0]);
    end
  endtask

  // Reference: wait is high whenever its request was seen at any of the
  // last HOLD+1 clock edges.
  task automatic test_wait();
    bit pw [$];
    bit pr [$];
    bit hw [$];
    bit hr [$];
    bit ew;
    bit er;
    int wr_high;
    pw = '{1,1,1,0,0,0,0,0,0,0,0,0,0, 1,0,0,1,0,0,0,1,0,0,0,0,0,0,0,0,0};
    for (int i = 0; i < pw.size(); i++) pr.push_back(1'b0);
    for (int i = 0; i < 200; i++) begin
      pw.push_back($urandom_range(0, 5) == 0);
      pr.push_back($urandom_range(0, 4) == 0);
    end
    wr_high = 0;
    @(negedge clk);
    for (int i = 0; i < pw.size(); i++) begin
      wr_wait_req = pw[i];
      rd_wait_req = pr[i];
      @(posedge clk);
      hw.push_back(pw[i]);
      hr.push_back(pr[i]);
      if (hw.size() > HOLD + 1) void'(hw.pop_front());
      if (hr.size() > HOLD + 1) void'(hr.pop_front());
      @(negedge clk);
      ew = 1'b0;
      er = 1'b0;
      foreach (hw[j]) ew |= hw[j];
      foreach (hr[j]) er |= hr[j];
      if (i < 13 && rx_wr_wait === 1'b1) wr_high++;
      checks += 2;
      if (rx_wr_wait !== ew) begin
        failures++; $display("FAIL wr_wait cyc=%0d got=%b exp=%b", i, rx_wr_wait, ew);
      end
      if (rx_rd_wait !== er) begin
        failures++; $display("FAIL rd_wait cyc=%0d got=%b exp=%b", i, rx_rd_wait, er);
      end
      if (i == 12) begin
        checks++;
        if (wr_high !== 7) begin
          failures++; $display("FAIL wr_wait_len got=%0d exp=7", wr_high);
        end
      end
    end
    wr_wait_req = 1'b0;
    rd_wait_req = 1'b0;
  endtask

  initial begin
    test_reset();
    test_aligned();
    test_offset();
    test_partial();
    test_back_to_back();
    test_random_bursts();
    test_glitch_reset();
    test_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
